// File: rtl/wm_pkg.sv
// Shared types and defaults for the washing-machine programme controller.
// State encoding, default phase durations and the rinse-count clamp.
package wm_pkg;

  typedef enum logic [3:0] {
    IDLE     = 4'd0,
    FILL     = 4'd1,
    WASH     = 4'd2,
    DRAIN    = 4'd3,
    RINSE    = 4'd4,
    SPIN     = 4'd5,
    COMPLETE = 4'd6,
    PAUSED   = 4'd7,
    ABORT    = 4'd8
  } wm_state_t;

  localparam int DEF_CNT_W     = 8;
  localparam int DEF_FILL_T    = 4;
  localparam int DEF_WASH_T    = 10;
  localparam int DEF_DRAIN_T   = 3;
  localparam int DEF_RINSE_T   = 5;
  localparam int DEF_SPIN_T    = 7;
  localparam int DEF_MAX_RINSE = 3;

  function automatic logic [1:0] clamp_rinse(input logic [1:0] req, input int max_n);
    if (int'(req) > max_n) return 2'(max_n);
    return req;
  endfunction

endpackage

// File: rtl/wm_phase_timer.sv
// Phase timer: counts cycles spent in the current phase, frozen by hold.
// expire flags the last cycle of a phase of length dur.
module wm_phase_timer #(
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             hold,
  input  logic [CNT_W-1:0] dur,
  output logic [CNT_W-1:0] count,
  output logic             expire
);

  always_ff @(posedge clk or posedge rst) begin
    if (rst)        count <= '0;
    else if (clr)   count <= '0;
    else if (!hold) count <= count + 1'b1;
  end

  assign expire = (count == dur - 1'b1);

endmodule

// File: rtl/wm_cycle_ctrl.sv
// Washing-machine programme controller: fill, wash, drain, N rinses, spin.
// Optional remaining-time output enabled by defining WM_TIME_LEFT_EN.
module wm_cycle_ctrl
  import wm_pkg::*;
#(
  parameter int CNT_W     = DEF_CNT_W,
  parameter int FILL_T    = DEF_FILL_T,
  parameter int WASH_T    = DEF_WASH_T,
  parameter int DRAIN_T   = DEF_DRAIN_T,
  parameter int RINSE_T   = DEF_RINSE_T,
  parameter int SPIN_T    = DEF_SPIN_T,
  parameter int MAX_RINSE = DEF_MAX_RINSE
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             stop,
  input  logic             pause,
  input  logic             door_closed,
  input  logic [1:0]       cfg_rinse_n,
  output logic [3:0]       state,
  output logic             valve_fill,
  output logic             pump_drain,
  output logic             motor_wash,
  output logic             motor_spin,
  output logic             door_lock,
  output logic             busy,
  output logic             done,
  output logic [1:0]       rinse_idx
`ifdef WM_TIME_LEFT_EN
  ,
  output logic [CNT_W-1:0] time_left
`endif
);

  localparam int DMAX = (1 << CNT_W) - 1;

  if (FILL_T < 1 || FILL_T > DMAX || WASH_T < 1 || WASH_T > DMAX ||
      DRAIN_T < 1 || DRAIN_T > DMAX || RINSE_T < 1 || RINSE_T > DMAX ||
      SPIN_T < 1 || SPIN_T > DMAX) begin : g_bad_duration
    $error("wm_cycle_ctrl: phase durations must lie in 1..2**CNT_W-1");
  end
  if (MAX_RINSE < 0 || MAX_RINSE > 3) begin : g_bad_max_rinse
    $error("wm_cycle_ctrl: MAX_RINSE must lie in 0..3");
  end

  wm_state_t        cur, nxt, saved, phase;
  logic [1:0]       rinse_n;
  logic [CNT_W-1:0] dur, count;
  logic             expire, run, timed, clr, hold;

  assign state = cur;
  assign run   = (cur == FILL) || (cur == WASH) || (cur == DRAIN) ||
                 (cur == RINSE) || (cur == SPIN);
  assign timed = run || (cur == ABORT);

  // Pause and resume keep the timer; every other state change restarts it.
  assign clr  = !(timed || cur == PAUSED) ||
                ((nxt != cur) && (nxt != PAUSED) && !(cur == PAUSED && nxt != ABORT));
  assign hold = (cur == PAUSED) || (nxt == PAUSED);

  always_comb begin
    phase = (cur == PAUSED) ? saved : cur;
    case (phase)
      FILL:    dur = CNT_W'(FILL_T);
      WASH:    dur = CNT_W'(WASH_T);
      RINSE:   dur = CNT_W'(RINSE_T);
      SPIN:    dur = CNT_W'(SPIN_T);
      default: dur = CNT_W'(DRAIN_T);
    endcase
  end

  wm_phase_timer #(.CNT_W(CNT_W)) u_timer (
    .clk    (clk),
    .rst    (rst),
    .clr    (clr),
    .hold   (hold),
    .dur    (dur),
    .count  (count),
    .expire (expire)
  );

`ifdef WM_TIME_LEFT_EN
  assign time_left = (timed || cur == PAUSED) ? (dur - 1'b1 - count) : '0;
`else
  logic unused_count;
  assign unused_count = &{1'b0, count};
`endif

  // Priority: stop, then door-open/pause, then phase timeout.
  always_comb begin
    nxt = cur;
    case (cur)
      IDLE:     if (start && door_closed && !stop) nxt = FILL;
      FILL, WASH, DRAIN, RINSE, SPIN: begin
        if (stop)                        nxt = ABORT;
        else if (pause || !door_closed)  nxt = PAUSED;
        else if (expire) begin
          case (cur)
            FILL:    nxt = WASH;
            WASH:    nxt = DRAIN;
            DRAIN:   nxt = (rinse_idx < rinse_n) ? RINSE : SPIN;
            RINSE:   nxt = DRAIN;
            default: nxt = COMPLETE;
          endcase
        end
      end
      PAUSED: begin
        if (stop)                                   nxt = ABORT;
        else if (start && !pause && door_closed)    nxt = saved;
      end
      ABORT:    if (expire) nxt = IDLE;
      default:  nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cur        <= IDLE;
      saved      <= IDLE;
      rinse_n    <= '0;
      rinse_idx  <= '0;
      valve_fill <= 1'b0;
      pump_drain <= 1'b0;
      motor_wash <= 1'b0;
      motor_spin <= 1'b0;
      door_lock  <= 1'b0;
      busy       <= 1'b0;
      done       <= 1'b0;
    end else begin
      cur <= nxt;
      if (nxt == PAUSED && cur != PAUSED) saved <= cur;
      if (cur == IDLE && nxt == FILL) begin
        rinse_n   <= clamp_rinse(cfg_rinse_n, MAX_RINSE);
        rinse_idx <= '0;
      end else if (cur == RINSE && nxt == DRAIN) begin
        rinse_idx <= rinse_idx + 2'd1;
      end
      valve_fill <= (nxt == FILL) || (nxt == RINSE);
      motor_wash <= (nxt == WASH) || (nxt == RINSE);
      pump_drain <= (nxt == DRAIN) || (nxt == SPIN) || (nxt == ABORT);
      motor_spin <= (nxt == SPIN);
      door_lock  <= (nxt != IDLE) && (nxt != COMPLETE);
      busy       <= (nxt != IDLE);
      done       <= (nxt == COMPLETE);
    end
  end

endmodule

// File: doc/wm_cycle_ctrl.md
Name: wm_cycle_ctrl

Overview:
Parametrised washing-machine programme controller; successor to the single-rinse fixed-timing controller.
- Sequences fill, wash, drain, a runtime-selectable number of rinse/drain passes, spin and complete.
- Adds pause/resume, a door interlock and an abort-drain path.
- Sits between the front-panel input logic and the valve/pump/motor drivers; all timing is in clk cycles.

Parameters:
CNT_W, 8, width of phase timer and duration parameters
FILL_T, 4, fill phase length in cycles
WASH_T, 10, wash phase length
DRAIN_T, 3, drain phase length (also used for abort drain)
RINSE_T, 5, rinse phase length
SPIN_T, 7, spin phase length
MAX_RINSE, 3, maximum rinse passes; cfg_rinse_n is clamped to this

Ports:
clk  in  1  clock
rst  in  1  reset, asynchronous, active-high
start  in  1  level; begins programme from IDLE, resumes from PAUSED
stop  in  1  level; aborts programme
pause  in  1  level; holds current phase while high
door_closed  in  1  door sensor, 1 = closed
cfg_rinse_n  in  2  rinse passes requested; sampled only on IDLE->FILL
state  out  4  current state encoding (wm_pkg)
valve_fill  out  1  water inlet valve
pump_drain  out  1  drain pump
motor_wash  out  1  low-speed drum drive
motor_spin  out  1  high-speed drum drive
door_lock  out  1  door latch
busy  out  1  high in every state except IDLE
done  out  1  one-cycle pulse on COMPLETE entry
rinse_idx  out  2  rinse passes already finished in this programme

Behaviour:
- Reset: state=IDLE; phase timer=0; rinse_idx=0; every output 0.
- States: IDLE, FILL, WASH, DRAIN, RINSE, SPIN, COMPLETE, PAUSED, ABORT.
- Phase timer:
  - Clears to 0 on every state change and increments each cycle while in a timed state.
  - A phase with length D occupies exactly D cycles; it exits when timer == D-1.
  - Durations must satisfy 1 <= D <= 2**CNT_W-1; check with an elaboration-time assertion.
- Outputs, registered and decoded from the current state:
  - FILL: valve_fill.
  - WASH: motor_wash.
  - DRAIN: pump_drain.
  - RINSE: valve_fill and motor_wash.
  - SPIN: pump_drain and motor_spin.
  - ABORT: pump_drain.
  - door_lock is high in FILL through SPIN, PAUSED and ABORT.
- Transitions:
  - IDLE -> FILL: start & door_closed & !stop. Latch rinse_n = min(cfg_rinse_n, MAX_RINSE) and clear rinse_idx.
  - FILL -> WASH -> DRAIN on timeout.
  - DRAIN timeout: rinse_idx < rinse_n -> RINSE; otherwise -> SPIN.
  - RINSE -> DRAIN on timeout; rinse_idx increments on that exit.
  - SPIN -> COMPLETE on timeout.
  - COMPLETE lasts 1 cycle, pulses done, then returns to IDLE. rinse_idx holds its final value until the next start.
- Pause:
  - Any timed state goes to PAUSED when pause=1 or door_closed=0.
  - PAUSED saves the return state and freezes the timer; all actuators are off and door_lock stays 1.
  - PAUSED returns to the saved state, with the timer continuing, when start=1 & pause=0 & door_closed=1.
- Abort:
  - stop=1 in any timed state or PAUSED -> ABORT.
  - ABORT drains for DRAIN_T cycles, then goes to IDLE with the door unlocked.
  - Stop is ignored inside ABORT.
- Priority within one cycle: rst > stop > door open/pause > timeout.
  - start & stop together in IDLE: stay in IDLE.
  - Timeout in the same cycle as pause: PAUSED wins and the saved state is the current state.
- cfg_rinse_n = 0: DRAIN goes straight to SPIN.
- Reset mid-programme: immediate IDLE; door unlocks on the reset edge.

Optional Feature:
WM_TIME_LEFT_EN:
- Defined: adds output time_left [CNT_W-1:0] = D-1-timer in timed states. It holds its value in PAUSED and is 0 in IDLE and COMPLETE.
- Undefined: no port, no subtractor; all other behaviour is identical.

Decomposition:
- wm_pkg: state enum, default duration constants, clamp function for rinse count.
- Sub-module wm_phase_timer: inputs clr, hold, dur; outputs count, expire. Instantiated once.

Test Plan:
- Nominal run: start with door closed, cfg_rinse_n=2 -> sequence FILL4, WASH10, DRAIN3, RINSE5, DRAIN3, RINSE5, DRAIN3, SPIN7. done pulses at cycle 41 after start; rinse_idx=2.
- Pause: assert pause at WASH timer=6 for 5 cycles, then start -> WASH resumes at timer=6; total programme length grows by exactly 6 cycles (5 paused plus the 1-cycle resume); all actuators off while paused.
- Door opens during SPIN -> PAUSED next cycle, motor_spin=0, door_lock=1. No resume while door_closed=0.
- Stop in RINSE -> ABORT with pump_drain for 3 cycles, then IDLE with door_lock=0, busy=0, no done pulse.
- Edges:
  - start & stop together in IDLE -> stays IDLE.
  - cfg_rinse_n=3 with MAX_RINSE=1 -> exactly one RINSE.
  - cfg_rinse_n=0 -> no RINSE.
  - Async rst mid-FILL -> all outputs 0 immediately.
